// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Purpose  : Shared types and constants for the write-back trace buffer.
//            trace_entry_t is one retired register-file write
//            {pc, addr, data}, 69 bits packed.
// Revision : 1.0  initial release
// ============================================================================
package trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } trace_entry_t;

    // Saturation ceiling of the dropped-record counter
    localparam logic [15:0] TRACE_DROP_MAX = 16'hFFFF;

endpackage : trace_pkg
`default_nettype wire

// File: rtl/wb_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_trace_buffer_if
// Purpose  : Bundles the WB-stage tap and the valid/ready trace read port.
//            master : drives wb_* and out_ready, observes out_*
//            slave  : the trace buffer (consumes wb_*, produces out_*)
// Revision : 1.0  initial release
// ============================================================================
interface wb_trace_buffer_if;
    logic        wb_en;
    logic [31:0] wb_pc;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_addr;
    logic [31:0] out_data;

    modport master (
        output wb_en, wb_pc, wb_addr, wb_data, out_ready,
        input  out_valid, out_pc, out_addr, out_data
    );

    modport slave (
        input  wb_en, wb_pc, wb_addr, wb_data, out_ready,
        output out_valid, out_pc, out_addr, out_data
    );
endinterface : wb_trace_buffer_if
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo
// Purpose  : Show-ahead synchronous FIFO of trace_entry_t with occupancy count.
//            The caller guarantees push only when space exists (or a pop
//            happens in the same cycle) and pop only when count != 0.
// Ports    : clk, reset (async, active-high)
//            push/wr_entry  - write side
//            pop/rd_entry   - read side, rd_entry reflects head of queue
//            count          - records currently held (0..DEPTH)
// Revision : 1.0  initial release
// ============================================================================
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         push,
    input  wire logic         pop,
    input  wire trace_entry_t wr_entry,
    output trace_entry_t      rd_entry,
    output logic [PTR_W:0]    count
);

    trace_entry_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [PTR_W:0]   count_d,  count_q;

    // Pointers wrap naturally because DEPTH is a power of two; full versus
    // empty is resolved by count, never by pointer comparison.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; contents are only meaningful while count != 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end

    assign rd_entry = mem[rd_ptr_q];
    assign count    = count_q;

endmodule : trace_fifo
`default_nettype wire

// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wb_trace_buffer
// Purpose  : Records every retired register-file write (except to $0) from
//            the WB stage into a trace FIFO drained over a valid/ready port.
//            A full buffer drops records and counts them; it never stalls.
// Ports    : clk, reset (async, active-high)
//            bus       - WB tap inputs and trace read port (slave modport)
//            count     - records currently held
//            overflow  - sticky, set once any record was dropped
//            drop_cnt  - dropped records, saturating at 16'hFFFF
// Revision : 1.0  initial release
// ============================================================================
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic       clk,
    input  wire logic       reset,
    wb_trace_buffer_if.slave bus,
    output logic [PTR_W:0]  count,
    output logic            overflow,
    output logic [15:0]     drop_cnt
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    trace_entry_t wr_entry;
    trace_entry_t rd_entry;
    logic         push_req;
    logic         pop;
    logic         push_ok;
    logic         drop;
    logic         overflow_d, overflow_q;
    logic [15:0]  drop_cnt_d, drop_cnt_q;

    always_comb begin
        push_req = bus.wb_en && (bus.wb_addr != 5'd0);
        pop      = bus.out_valid && bus.out_ready;
        // A full buffer still accepts when the head leaves in the same cycle,
        // which sustains one-in/one-out at full occupancy.
        push_ok  = push_req && ((count != FULL_COUNT) || pop);
        drop     = push_req && !push_ok;
        wr_entry = '{pc: bus.wb_pc, addr: bus.wb_addr, data: bus.wb_data};

        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != TRACE_DROP_MAX))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_ok),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .count    (count)
    );

    // out_valid depends only on registered count, so out_ready never
    // reaches it combinationally.
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = rd_entry.pc;
    assign bus.out_addr  = rd_entry.addr;
    assign bus.out_data  = rd_entry.data;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;

endmodule : wb_trace_buffer
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_trace_buffer
// Purpose  : Self-checking bench for wb_trace_buffer with a queue scoreboard.
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_trace_buffer;
    import trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk;
    logic             reset;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic [15:0]      drop_cnt;

    wb_trace_buffer_if tif ();

    wb_trace_buffer #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (tif),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard and reference model state
    trace_entry_t exp_q[$];
    logic         model_ovf   = 1'b0;
    logic [15:0]  model_drops = 16'd0;

    // One clock of stimulus, entered and left on a falling edge. Captures the
    // head presented before the edge and, if a pop happens, the record the
    // scoreboard expects there. Updates the model; makes no comparisons.
    task automatic apply(input logic en, input logic [31:0] pc,
                         input logic [4:0] addr, input logic [31:0] data,
                         input logic rdy, output logic popped,
                         output trace_entry_t got, output trace_entry_t exp);
        logic push_req;
        logic accept;
        popped   = (exp_q.size() != 0) && rdy;
        got      = '{pc: tif.out_pc, addr: tif.out_addr, data: tif.out_data};
        exp      = popped ? exp_q[0] : '0;
        push_req = en && (addr != 5'd0);
        accept   = push_req && ((exp_q.size() < DEPTH) || popped);
        tif.wb_en     = en;
        tif.wb_pc     = pc;
        tif.wb_addr   = addr;
        tif.wb_data   = data;
        tif.out_ready = rdy;
        if (popped) void'(exp_q.pop_front());
        if (accept) exp_q.push_back('{pc: pc, addr: addr, data: data});
        else if (push_req) begin
            model_ovf = 1'b1;
            if (model_drops != 16'hFFFF) model_drops = model_drops + 16'd1;
        end
        @(negedge clk);
        tif.wb_en     = 1'b0;
        tif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tif.wb_en = 1'b0; tif.wb_pc = '0; tif.wb_addr = '0; tif.wb_data = '0;
        tif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tif.out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_push();
        logic p; trace_entry_t g, e;
        apply(1'b1, 32'h3000, 5'd8, 32'h1234, 1'b0, p, g, e);
        checks++; if (tif.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", tif.out_valid); end
        checks++; if (tif.out_pc !== 32'h3000) begin errors++; $display("FAIL single_pc: got %h expected 00003000", tif.out_pc); end
        checks++; if (tif.out_addr !== 5'd8) begin errors++; $display("FAIL single_addr: got %0d expected 8", tif.out_addr); end
        checks++; if (tif.out_data !== 32'h1234) begin errors++; $display("FAIL single_data: got %h expected 00001234", tif.out_data); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        apply(1'b0, '0, '0, '0, 1'b1, p, g, e);
        checks++; if (!p || g !== e) begin errors++; $display("FAIL single_pop: got %h expected %h", g, e); end
        checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", tif.out_valid); end
    endtask

    task automatic test_zero_filter();
        logic p; trace_entry_t g, e;
        apply(1'b1, 32'h4000, 5'd0, 32'hFFFF, 1'b0, p, g, e);
        checks++; if (count !== '0) begin errors++; $display("FAIL zero_count: got %0d expected 0", count); end
        checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid: got %b expected 0", tif.out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL zero_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_overflow();
        logic p; trace_entry_t g, e;
        for (int i = 1; i <= 20; i++)
            apply(1'b1, 32'h1000 + 32'(i*4), 5'(i), 32'hA000 + 32'(i), 1'b0, p, g, e);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", count); end
        checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL ovf_flag: got %b expected %b", overflow, model_ovf); end
        checks++; if (drop_cnt !== model_drops) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected %0d", drop_cnt, model_drops); end
        for (int i = 1; i <= 16; i++) begin
            apply(1'b0, '0, '0, '0, 1'b1, p, g, e);
            checks++; if (!p || g !== e || g.addr !== 5'(i)) begin errors++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, g, e); end
        end
        checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid: got %b expected 0", tif.out_valid); end
    endtask

    task automatic test_full_push_pop();
        logic p; trace_entry_t g, e;
        for (int i = 0; i < 16; i++)
            apply(1'b1, 32'h2000 + 32'(i), 5'(i % 31 + 1), 32'($urandom), 1'b0, p, g, e);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_fill_count: got %0d expected 16", count); end
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 32'h5000 + 32'(i), 5'(i + 20), 32'($urandom), 1'b1, p, g, e);
            checks++; if (!p || g !== e) begin errors++; $display("FAIL full_pp_pop_%0d: got %h expected %h", i, g, e); end
            checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_pp_count_%0d: got %0d expected 16", i, count); end
        end
        checks++; if (drop_cnt !== model_drops) begin errors++; $display("FAIL full_pp_drop_cnt: got %0d expected %0d", drop_cnt, model_drops); end
        while (exp_q.size() != 0) begin
            apply(1'b0, '0, '0, '0, 1'b1, p, g, e);
            checks++; if (!p || g !== e) begin errors++; $display("FAIL full_drain: got %h expected %h", g, e); end
        end
        checks++; if (tif.out_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL full_empty: got valid=%b count=%0d expected 0/0", tif.out_valid, count); end
    endtask

    task automatic test_back_to_back();
        logic p; trace_entry_t g, e;
        logic [4:0] a;
        for (int i = 0; i < 40; i++) begin
            a = 5'(i % 31 + 1);
            apply(1'b1, 32'h8000 + 32'(i*4), a, 32'($urandom), 1'b1, p, g, e);
            if (i > 0) begin
                checks++; if (!p || g !== e) begin errors++; $display("FAIL b2b_pop_%0d: got %h expected %h", i, g, e); end
            end
            checks++; if (tif.out_valid !== 1'b1 || tif.out_addr !== a || count !== 5'd1) begin
                errors++; $display("FAIL b2b_head_%0d: got valid=%b addr=%0d count=%0d expected 1/%0d/1", i, tif.out_valid, tif.out_addr, count, a);
            end
        end
        apply(1'b0, '0, '0, '0, 1'b1, p, g, e);
        checks++; if (!p || g !== e) begin errors++; $display("FAIL b2b_last: got %h expected %h", g, e); end
        checks++; if (drop_cnt !== model_drops) begin errors++; $display("FAIL b2b_drop_cnt: got %0d expected %0d", drop_cnt, model_drops); end
    endtask

    task automatic test_async_reset();
        logic p; trace_entry_t g, e;
        for (int i = 0; i < 9; i++)
            apply(1'b1, 32'h9000 + 32'(i), 5'(i + 1), 32'(i), 1'b0, p, g, e);
        checks++; if (count !== 5'd9) begin errors++; $display("FAIL arst_pre_count: got %0d expected 9", count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (count !== '0) begin errors++; $display("FAIL arst_count: got %0d expected 0", count); end
        checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", tif.out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow: got %b expected 0", overflow); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL arst_drop_cnt: got %0d expected 0", drop_cnt); end
        exp_q.delete();
        model_ovf   = 1'b0;
        model_drops = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        apply(1'b1, 32'hC000, 5'd3, 32'hBEEF, 1'b0, p, g, e);
        checks++; if (count !== 5'd1 || tif.out_pc !== 32'hC000) begin errors++; $display("FAIL arst_recover: got count=%0d pc=%h expected 1/0000c000", count, tif.out_pc); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_zero_filter();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_trace_buffer
`default_nettype wire
